// File: rtl/resp_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// CTRL bit positions and default address map.
package resp_pkg;

  localparam logic [31:0] DefDataBase = 32'h1001_0000;
  localparam logic [31:0] DefMmioBase = 32'hFFFF_0100;

  typedef enum logic [2:0] {
    OffTimeLo = 3'd0,
    OffTimeHi = 3'd1,
    OffCmpLo  = 3'd2,
    OffCmpHi  = 3'd3,
    OffCtrl   = 3'd4
  } mmio_off_e;

  localparam int unsigned CtrlCntEn   = 0;
  localparam int unsigned CtrlIrqEn   = 1;
  localparam int unsigned CtrlPending = 2;

endpackage

// File: rtl/datamem_responder_if.sv
// Data-memory bus between the CPU (master) and the responder (slave).
interface datamem_responder_if;

  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;

  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData
  );

  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData
  );

endinterface

// File: rtl/resp_timer64.sv
// 64-bit free-running timer with read shadow; compare/PENDING/IRQ logic only
// when RESP_TIMER_IRQ_EN is defined.
module resp_timer64
  import resp_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [2:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [63:0] count_q, count_d;
  logic [31:0] shadow_q, shadow_d;
  logic        cnt_en_q, cnt_en_d;
  logic        wr_ctrl;
  logic        unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_comb begin
    wr_ctrl  = wr_en_i && (off_i == OffCtrl);
    count_d  = cnt_en_q ? count_q + 64'd1 : count_q;
    if (wr_en_i && (off_i == OffTimeLo)) count_d = '0;
    // High word captured together with the low word so a lo-then-hi read is coherent.
    shadow_d = (rd_en_i && (off_i == OffTimeLo)) ? count_q[63:32] : shadow_q;
    cnt_en_d = wr_ctrl ? wdata_i[CtrlCntEn] : cnt_en_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      count_q  <= '0;
      shadow_q <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      cnt_en_q <= cnt_en_d;
    end
  end

`ifdef RESP_TIMER_IRQ_EN
  logic [63:0] cmp_q, cmp_d;
  logic        irq_en_q, irq_en_d;
  logic        pending_q, pending_d;
  logic        match, clr;

  always_comb begin
    cmp_d    = cmp_q;
    irq_en_d = irq_en_q;
    if (wr_en_i && (off_i == OffCmpLo)) cmp_d[31:0]  = wdata_i;
    if (wr_en_i && (off_i == OffCmpHi)) cmp_d[63:32] = wdata_i;
    if (wr_ctrl) irq_en_d = wdata_i[CtrlIrqEn];
    match     = cnt_en_q && (count_q == cmp_q);
    clr       = (wr_ctrl && wdata_i[CtrlPending]) || (wr_en_i && (off_i == OffCmpLo));
    // A match in the same cycle as a clear leaves PENDING set.
    pending_d = match || (pending_q && !clr);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cmp_q     <= '0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
    end
  end

  always_comb irq_o = pending_q && irq_en_q;
`else
  always_comb irq_o = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    case (off_i)
      OffTimeLo: rdata_o = count_q[31:0];
      OffTimeHi: rdata_o = shadow_q;
`ifdef RESP_TIMER_IRQ_EN
      OffCmpLo:  rdata_o = cmp_q[31:0];
      OffCmpHi:  rdata_o = cmp_q[63:32];
      OffCtrl: begin
        rdata_o[CtrlCntEn]   = cnt_en_q;
        rdata_o[CtrlIrqEn]   = irq_en_q;
        rdata_o[CtrlPending] = pending_q;
      end
`else
      OffCtrl:   rdata_o[CtrlCntEn] = cnt_en_q;
`endif
      default:   rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/datamem_responder.sv
// Data RAM plus timer MMIO window on the CPU data bus. Optional compare
// interrupt enabled by defining RESP_TIMER_IRQ_EN.
module datamem_responder
  import resp_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DefDataBase,
  parameter int unsigned DATA_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = DefMmioBase,
  parameter int unsigned IRQ_BIT    = 7
) (
  input  logic                iCLK,
  input  logic                iRST,
  datamem_responder_if.slave  bus,
  output logic [7:0]          oPendingInterrupt
);

  localparam int unsigned IdxW     = $clog2(DATA_WORDS);
  localparam logic [31:0] RamBytes = 32'(4 * DATA_WORDS);
  localparam logic [7:0]  IrqMask  = 8'(1 << IRQ_BIT);

  logic [31:0]     ram_off;
  logic            ram_hit;
  logic [IdxW-1:0] ram_idx;
  logic            mmio_hit;
  logic            mmio_wr;
  logic            mmio_rd;
  logic [31:0]     timer_rdata;
  logic            timer_irq;
  logic [31:0]     mem [DATA_WORDS];

  always_comb begin
    ram_off  = bus.iAddress - DATA_BASE;
    ram_hit  = (bus.iAddress >= DATA_BASE) && (ram_off < RamBytes);
    ram_idx  = ram_off[IdxW+1:2];
    mmio_hit = bus.iAddress[31:5] == MMIO_BASE[31:5];
    // Timer registers only accept full-word stores.
    mmio_wr  = bus.iWriteEnable && mmio_hit && (bus.iByteEnable == 4'hF);
    mmio_rd  = bus.iReadEnable && mmio_hit;
  end

  always_ff @(posedge iCLK) begin
    if (bus.iWriteEnable && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.iByteEnable[b]) mem[ram_idx][8*b +: 8] <= bus.iWriteData[8*b +: 8];
      end
    end
  end

  resp_timer64 u_timer (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .wr_en_i (mmio_wr),
    .rd_en_i (mmio_rd),
    .off_i   (bus.iAddress[4:2]),
    .wdata_i (bus.iWriteData),
    .rdata_o (timer_rdata),
    .irq_o   (timer_irq)
  );

  always_comb begin
    bus.oReadData = '0;
    if (bus.iReadEnable) begin
      if (ram_hit)       bus.oReadData = mem[ram_idx];
      else if (mmio_hit) bus.oReadData = timer_rdata;
    end
  end

  always_comb oPendingInterrupt = timer_irq ? IrqMask : 8'h00;

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench for datamem_responder: RAM lanes/decode, timer reads,
// compare interrupt (or its absence without RESP_TIMER_IRQ_EN) and reset.
module tb_datamem_responder;

  localparam logic [31:0] ATLo  = 32'hFFFF_0100;
  localparam logic [31:0] AThi  = 32'hFFFF_0104;
  localparam logic [31:0] ACLo  = 32'hFFFF_0108;
  localparam logic [31:0] ACHi  = 32'hFFFF_010C;
  localparam logic [31:0] ACtrl = 32'hFFFF_0110;
  localparam logic [31:0] AOff5 = 32'hFFFF_0114;
`ifdef RESP_TIMER_IRQ_EN
  localparam bit IrqBuilt = 1'b1;
`else
  localparam bit IrqBuilt = 1'b0;
`endif

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic [7:0] oPendingInterrupt;
  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];

  datamem_responder_if bus_if ();

  datamem_responder dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .bus               (bus_if),
    .oPendingInterrupt (oPendingInterrupt)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus_if.iAddress     = addr;
    bus_if.iWriteData   = data;
    bus_if.iByteEnable  = be;
    bus_if.iWriteEnable = 1'b1;
    bus_if.iReadEnable  = 1'b0;
    @(posedge iCLK);
    #1;
    bus_if.iWriteEnable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus_if.iAddress     = addr;
    bus_if.iByteEnable  = 4'hF;
    bus_if.iWriteEnable = 1'b0;
    bus_if.iReadEnable  = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge iCLK);
    obs_q.push_back(bus_if.oReadData);
    @(posedge iCLK);
    #1;
    bus_if.iReadEnable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    string n;
    bus_if.iAddress = '0; bus_if.iWriteData = '0; bus_if.iByteEnable = 4'h0;
    bus_if.iWriteEnable = 1'b0; bus_if.iReadEnable = 1'b0;
    iRST = 1'b1;
    idle(3);
    iRST = 1'b0;
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++;
      $display("FAIL reset_irq: got %h required 00", oPendingInterrupt);
    end
    idle(1);
    rd(ATLo, 32'h0, "reset_time_lo");
    rd(AThi, 32'h0, "reset_time_hi");
    rd(ACtrl, 32'h0, "reset_ctrl");
    rd(ACLo, 32'h0, "reset_cmp_lo");
    rd(ACHi, 32'h0, "reset_cmp_hi");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
  endtask

  task automatic test_ram();
    logic [31:0] e, o;
    string n;
    wr(32'h1001_0004, 32'hDEAD_BEEF, 4'hF);
    wr(32'h1001_0004, 32'h0000_5500, 4'b0010);
    rd(32'h1001_0004, 32'hDEAD_55EF, "ram_byte_lane1");
    rd(32'h1001_0007, 32'hDEAD_55EF, "ram_low_bits_ignored");
    wr(32'h1001_0004, 32'h1122_3344, 4'b1001);
    rd(32'h1001_0004, 32'h11AD_5544, "ram_lanes_0_3");
    wr(32'h1001_0000, 32'hA5A5_0001, 4'hF);
    wr(32'h1001_0FFC, 32'h0BAD_F00D, 4'hF);
    wr(32'h1001_1000, 32'h1234_5678, 4'hF);
    wr(32'h0000_0000, 32'hFFFF_FFFF, 4'hF);
    wr(32'h1000_FFFC, 32'h5555_AAAA, 4'hF);
    rd(32'h1001_1000, 32'h0, "unmapped_past_end");
    rd(32'h0000_0000, 32'h0, "unmapped_zero");
    rd(32'h1001_0000, 32'hA5A5_0001, "ram_first_word");
    rd(32'h1001_0FFC, 32'h0BAD_F00D, "ram_last_word");
    rd(32'h1001_0004, 32'h11AD_5544, "ram_word1_unchanged");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
    bus_if.iAddress = 32'h1001_0004;
    bus_if.iReadEnable = 1'b0;
    @(negedge iCLK);
    checks++;
    if (bus_if.oReadData !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled: got %h required 00000000", bus_if.oReadData);
    end
    idle(1);
  endtask

  task automatic test_timer_count();
    logic [31:0] e, o;
    string n;
    wr(ACtrl, 32'h1, 4'h7);
    rd(ACtrl, 32'h0, "ctrl_partial_write_ignored");
    rd(ATLo, 32'h0, "count_not_enabled");
    rd(AOff5, 32'h0, "offset5_reads_zero");
    wr(ACtrl, 32'h1, 4'hF);
    idle(10);
    rd(ATLo, 32'd10, "count_after_10");
    rd(AThi, 32'd0, "count_hi_zero");
    rd(ATLo, 32'd12, "count_running");
    wr(ACtrl, 32'h0, 4'hF);
    rd(ATLo, 32'd14, "count_stopped");
    wr(ATLo, 32'h0000_1234, 4'hF);
    rd(ATLo, 32'd0, "time_lo_write_clears");
    // Preload just below a low-word carry while counting is stopped.
    force dut.u_timer.count_q = 64'h0000_0005_FFFF_FFFF;
    @(posedge iCLK);
    #1;
    release dut.u_timer.count_q;
    wr(ACtrl, 32'h1, 4'hF);
    rd(ATLo, 32'hFFFF_FFFF, "carry_lo");
    rd(AThi, 32'h0000_0005, "carry_hi_shadow_precarry");
    rd(ATLo, 32'h0000_0001, "carry_lo_after");
    rd(AThi, 32'h0000_0006, "carry_hi_after");
    wr(ACtrl, 32'h0, 4'hF);
    force dut.u_timer.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge iCLK);
    #1;
    release dut.u_timer.count_q;
    wr(ACtrl, 32'h1, 4'hF);
    rd(ATLo, 32'hFFFF_FFFF, "wrap_lo");
    rd(AThi, 32'hFFFF_FFFF, "wrap_hi");
    rd(ATLo, 32'h0000_0001, "wrap_lo_after");
    rd(AThi, 32'h0000_0000, "wrap_hi_after");
    wr(ACtrl, 32'h0, 4'hF);
    wr(ATLo, 32'h0, 4'hF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] e, o;
    string n;
    logic [7:0] irq_exp;
    irq_exp = IrqBuilt ? 8'h80 : 8'h00;
    wr(ACHi, 32'h0, 4'hF);
    wr(ACLo, 32'd20, 4'hF);
    wr(ACtrl, 32'h3, 4'hF);
    idle(20);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++; $display("FAIL irq_before_match: got %h required 00", oPendingInterrupt);
    end
    idle(1);
    rd(ACtrl, IrqBuilt ? 32'h7 : 32'h1, "ctrl_pending");
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== irq_exp) begin
      errors++; $display("FAIL irq_after_match: got %h required %h", oPendingInterrupt, irq_exp);
    end
    wr(ACtrl, 32'h7, 4'hF);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++; $display("FAIL irq_w1c: got %h required 00", oPendingInterrupt);
    end
    wr(ATLo, 32'h0, 4'hF);
    idle(25);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== irq_exp) begin
      errors++; $display("FAIL irq_rematch: got %h required %h", oPendingInterrupt, irq_exp);
    end
    wr(ACLo, 32'd1000, 4'hF);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++; $display("FAIL irq_cmp_lo_clear: got %h required 00", oPendingInterrupt);
    end
    idle(1);
    rd(ACLo, IrqBuilt ? 32'd1000 : 32'd0, "cmp_lo_read");
    rd(ACHi, 32'd0, "cmp_hi_read");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
  endtask

  task automatic test_priority_and_reset();
    logic [31:0] e, o;
    string n;
    logic [7:0] irq_exp;
    irq_exp = IrqBuilt ? 8'h80 : 8'h00;
    wr(ACLo, 32'd10, 4'hF);
    wr(ATLo, 32'h0, 4'hF);
    idle(10);
    wr(ACtrl, 32'h7, 4'hF);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== irq_exp) begin
      errors++; $display("FAIL w1c_on_match: got %h required %h", oPendingInterrupt, irq_exp);
    end
    wr(ACtrl, 32'h7, 4'hF);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++; $display("FAIL w1c_off_match: got %h required 00", oPendingInterrupt);
    end
    wr(ATLo, 32'h0, 4'hF);
    idle(10);
    wr(ACLo, 32'd10, 4'hF);
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== irq_exp) begin
      errors++; $display("FAIL cmp_write_on_match: got %h required %h", oPendingInterrupt, irq_exp);
    end
    idle(1);
    iRST = 1'b1;
    wr(ACtrl, 32'h3, 4'hF);
    iRST = 1'b0;
    @(negedge iCLK);
    checks++;
    if (oPendingInterrupt !== 8'h00) begin
      errors++; $display("FAIL reset_mid_count_irq: got %h required 00", oPendingInterrupt);
    end
    idle(1);
    rd(ATLo, 32'h0, "reset_mid_count_time");
    rd(ACtrl, 32'h0, "reset_mid_count_ctrl");
    rd(ACLo, 32'h0, "reset_mid_count_cmp");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    string n;
    logic [31:0] model [8];
    wr(32'h1001_0008, 32'h1111_2222, 4'hF);
    bus_if.iAddress     = 32'h1001_0008;
    bus_if.iWriteData   = 32'hCAFE_F00D;
    bus_if.iByteEnable  = 4'hF;
    bus_if.iWriteEnable = 1'b1;
    bus_if.iReadEnable  = 1'b1;
    exp_q.push_back(32'h1111_2222);
    name_q.push_back("read_during_write_old");
    @(negedge iCLK);
    obs_q.push_back(bus_if.oReadData);
    @(posedge iCLK);
    #1;
    bus_if.iWriteEnable = 1'b0;
    bus_if.iReadEnable  = 1'b0;
    rd(32'h1001_0008, 32'hCAFE_F00D, "read_after_write_new");
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      wr(32'h1001_0100 + 32'(4 * i), model[i], 4'hF);
    end
    for (int i = 0; i < 8; i++) rd(32'h1001_0100 + 32'(4 * i), model[i], "b2b_word");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s: got %h required %h", n, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_timer_count();
    test_irq();
    test_priority_and_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
